// File: rtl/camera_responder_pkg.sv
// Shared definitions for the blob-tracker camera I2C responder: FSM encoding,
// register map and the read-data mux used by the top level.
package camera_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

  localparam logic [7:0] REG_CFG          = 8'h30;
  localparam logic [7:0] REG_AUX          = 8'h33;
  localparam logic [7:0] REG_FRAME        = 8'h36;
  localparam int         FRAME_LEN        = 16;
  localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h58;
  localparam logic [7:0] CFG_ENABLE       = 8'h08;

  // Byte returned for a given pointer; blob fields come from the snapshot.
  function automatic logic [7:0] read_data(
    input logic [7:0] ptr,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [3:0] size,
    input logic [7:0] r30,
    input logic [7:0] r33,
    input logic [7:0] pad
  );
    logic [7:0] idx;
    logic [7:0] data;
    idx  = ptr - REG_FRAME;
    data = 8'h00;
    if (ptr == REG_CFG) begin
      data = r30;
    end else if (ptr == REG_AUX) begin
      data = r33;
    end else if (ptr >= REG_FRAME) begin
      // Past the frame the pointer keeps returning padding until it wraps.
      if (idx >= 8'(FRAME_LEN)) begin
        data = pad;
      end else begin
        case (idx)
          8'd0:    data = 8'h00;
          8'd1:    data = x[7:0];
          8'd2:    data = y[7:0];
          8'd3:    data = {y[9:8], x[9:8], size};
          default: data = pad;
        endcase
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/camera_responder_i2c_line_sync.sv
// Two-flop synchronizers on SCL/SDA followed by SCL edge and START/STOP detection.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Bit 0 carries SCL, bit 1 carries SDA; all stages idle high.
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic [1:0] prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
      prev_reg <= 2'b11;
    end else begin
      meta_reg <= {sda_in, scl_in};
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sda       = sync_reg[1];
  assign scl_rise  = sync_reg[0] & ~prev_reg[0];
  assign scl_fall  = ~sync_reg[0] & prev_reg[0];
  assign start_det = sync_reg[0] & prev_reg[0] & prev_reg[1] & ~sync_reg[1];
  assign stop_det  = sync_reg[0] & prev_reg[0] & ~prev_reg[1] & sync_reg[1];

endmodule

// File: rtl/camera_responder.sv
// Camera I2C target: auto-incrementing register pointer, two config registers
// and a 16-byte blob frame read from a snapshot taken at the read-address ACK.
module camera_responder
  import camera_responder_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = DEFAULT_I2C_ADDR,
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [3:0] size_in,
  output logic [7:0] reg30,
  output logic [7:0] reg33,
  output logic       enabled,
  output logic       frame_read,
  output logic       busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (i2c_scl),
    .sda_in   (i2c_sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] rx_reg, rx_next;
  logic [6:0] tx_reg, tx_next;
  logic [7:0] ptr_reg, ptr_next;
  logic [7:0] cfg_reg, cfg_next;
  logic [7:0] aux_reg, aux_next;
  logic       enabled_reg, enabled_next;
  logic       oe_reg, oe_next;
  logic       busy_reg, busy_next;
  logic       frame_read_reg, frame_read_next;
  logic       rw_reg, rw_next;
  logic       ack_reg, ack_next;
  logic       first_reg, first_next;
  logic [9:0] snap_x_reg, snap_x_next;
  logic [9:0] snap_y_reg, snap_y_next;
  logic [3:0] snap_size_reg, snap_size_next;

  logic [7:0] rx_byte;
  logic [7:0] rd_data;
  logic       addr_match;
  logic       last_bit;

  assign rx_byte    = {rx_reg, sda};
  assign addr_match = (rx_byte[7:1] == I2C_ADDR);
  assign last_bit   = (bit_cnt_reg == 3'd7);
  assign rd_data    = read_data(ptr_reg, snap_x_reg, snap_y_reg, snap_size_reg,
                                cfg_reg, aux_reg, PAD_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = ADDR;
    end else if (stop_det) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:     state_next = IDLE;
        ADDR:     if (scl_rise && last_bit) state_next = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall && ack_reg) state_next = rw_reg ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (scl_rise && last_bit) state_next = WR_ACK;
        WR_ACK:   if (scl_fall && ack_reg) state_next = WR_BYTE;
        RD_BYTE:  if (scl_fall && last_bit) state_next = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda) state_next = IDLE;
          else if (scl_fall && ack_reg) state_next = RD_BYTE;
        end
        default:  state_next = IDLE;
      endcase
    end
  end

  // ack_reg marks the second half of any ACK slot: set once the ACK clock is under way.
  always_comb begin
    bit_cnt_next    = bit_cnt_reg;
    rx_next         = rx_reg;
    tx_next         = tx_reg;
    ptr_next        = ptr_reg;
    cfg_next        = cfg_reg;
    aux_next        = aux_reg;
    enabled_next    = enabled_reg;
    oe_next         = oe_reg;
    busy_next       = busy_reg;
    frame_read_next = 1'b0;
    rw_next         = rw_reg;
    ack_next        = ack_reg;
    first_next      = first_reg;
    snap_x_next     = snap_x_reg;
    snap_y_next     = snap_y_reg;
    snap_size_next  = snap_size_reg;
    if (start_det || stop_det) begin
      bit_cnt_next = 3'd0;
      busy_next    = 1'b0;
      oe_next      = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            rx_next      = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (last_bit && addr_match) begin
              busy_next  = 1'b1;
              rw_next    = rx_byte[0];
              ack_next   = 1'b0;
              first_next = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall && !ack_reg) begin
            oe_next  = 1'b1;
            ack_next = 1'b1;
            if (rw_reg) begin
              snap_x_next    = x_in;
              snap_y_next    = y_in;
              snap_size_next = size_in;
            end
          end else if (scl_fall) begin
            bit_cnt_next = 3'd0;
            tx_next      = rd_data[6:0];
            oe_next      = rw_reg ? ~rd_data[7] : 1'b0;
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            rx_next      = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (last_bit) begin
              ack_next = 1'b0;
              if (first_reg) begin
                ptr_next   = rx_byte;
                first_next = 1'b0;
              end else begin
                ptr_next = ptr_reg + 8'd1;
                if (ptr_reg == REG_CFG) begin
                  cfg_next     = rx_byte;
                  enabled_next = (rx_byte == CFG_ENABLE);
                end else if (ptr_reg == REG_AUX) begin
                  aux_next = rx_byte;
                end
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall && !ack_reg) begin
            oe_next  = 1'b1;
            ack_next = 1'b1;
          end else if (scl_fall) begin
            oe_next      = 1'b0;
            bit_cnt_next = 3'd0;
          end
        end
        RD_BYTE: begin
          if (scl_fall && last_bit) begin
            oe_next         = 1'b0;
            ack_next        = 1'b0;
            bit_cnt_next    = 3'd0;
            ptr_next        = ptr_reg + 8'd1;
            frame_read_next = (ptr_reg == REG_FRAME + 8'd3);
          end else if (scl_fall) begin
            oe_next      = ~tx_reg[6];
            tx_next      = {tx_reg[5:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && !sda) begin
            ack_next = 1'b1;
          end else if (scl_fall && ack_reg) begin
            bit_cnt_next = 3'd0;
            tx_next      = rd_data[6:0];
            oe_next      = ~rd_data[7];
          end
        end
        default: begin
          oe_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg    <= 3'd0;
      rx_reg         <= 7'd0;
      tx_reg         <= 7'd0;
      ptr_reg        <= 8'h00;
      cfg_reg        <= 8'h00;
      aux_reg        <= 8'h00;
      enabled_reg    <= 1'b0;
      oe_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      frame_read_reg <= 1'b0;
      rw_reg         <= 1'b0;
      ack_reg        <= 1'b0;
      first_reg      <= 1'b0;
      snap_x_reg     <= 10'd0;
      snap_y_reg     <= 10'd0;
      snap_size_reg  <= 4'd0;
    end else begin
      bit_cnt_reg    <= bit_cnt_next;
      rx_reg         <= rx_next;
      tx_reg         <= tx_next;
      ptr_reg        <= ptr_next;
      cfg_reg        <= cfg_next;
      aux_reg        <= aux_next;
      enabled_reg    <= enabled_next;
      oe_reg         <= oe_next;
      busy_reg       <= busy_next;
      frame_read_reg <= frame_read_next;
      rw_reg         <= rw_next;
      ack_reg        <= ack_next;
      first_reg      <= first_next;
      snap_x_reg     <= snap_x_next;
      snap_y_reg     <= snap_y_next;
      snap_size_reg  <= snap_size_next;
    end
  end

  assign i2c_sda_oe = oe_reg;
  assign reg30      = cfg_reg;
  assign reg33      = aux_reg;
  assign enabled    = enabled_reg;
  assign frame_read = frame_read_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_camera_responder.sv
// Bench for camera_responder: bit-banged I2C controller, table of pointer reads
// and hand-written write/read/reset sequences, with a byte scoreboard.
module tb_camera_responder;

  localparam int Q = 100;
  localparam int H = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       i2c_sda_oe;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic [3:0] size_in;
  logic [7:0] reg30;
  logic [7:0] reg33;
  logic       enabled;
  logic       frame_read;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~i2c_sda_oe;

  camera_responder #(.I2C_ADDR(7'h58), .PAD_BYTE(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .i2c_scl   (scl),
    .i2c_sda_in(sda_bus),
    .i2c_sda_oe(i2c_sda_oe),
    .x_in      (x_in),
    .y_in      (y_in),
    .size_in   (size_in),
    .reg30     (reg30),
    .reg33     (reg33),
    .enabled   (enabled),
    .frame_read(frame_read),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  int   fr_cnt = 0;
  int   oe_glitch = 0;
  int   mon_oe = 0;
  int   mon_busy = 0;
  logic mon_on = 1'b0;
  logic oe_prev = 1'b0;
  logic scl_prev = 1'b1;

  always @(posedge clk) if (frame_read) fr_cnt <= fr_cnt + 1;

  // SDA may only move while SCL is low (outside reset).
  always @(negedge clk) begin
    if (!reset && scl && scl_prev && (i2c_sda_oe !== oe_prev)) oe_glitch <= oe_glitch + 1;
    if (mon_on && i2c_sda_oe) mon_oe <= mon_oe + 1;
    if (mon_on && busy) mon_busy <= mon_busy + 1;
    oe_prev  <= i2c_sda_oe;
    scl_prev <= scl;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic sb_compare(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %02h, want <nothing queued>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl = 1'b1; #H;
    scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #(H/2);
    b = sda_bus; #(H/2);
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack);
  endtask

  // START, address+W, pointer, repeated START, address+R.
  task automatic open_read(input string tag, input logic [7:0] ptr);
    logic ack;
    bus_start();
    write_byte(8'hB0, ack); check({tag, " addr-w ack"}, ack, 1'b1);
    write_byte(ptr, ack);   check({tag, " ptr ack"}, ack, 1'b1);
    bus_start();
    write_byte(8'hB1, ack); check({tag, " addr-r ack"}, ack, 1'b1);
  endtask

  task automatic write_regs(input string tag, input logic [7:0] ptr, input logic [7:0] d);
    logic ack;
    bus_start();
    write_byte(8'hB0, ack); check({tag, " addr ack"}, ack, 1'b1);
    write_byte(ptr, ack);   check({tag, " ptr ack"}, ack, 1'b1);
    write_byte(d, ack);     check({tag, " data ack"}, ack, 1'b1);
    bus_stop();
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] size;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       ack;
    logic       b;
    int         fr0;

    // Byte 3 packs {y[9:8], x[9:8], size}; reads run after config so 0x30=08, 0x33=33.
    tbl[0]  = '{8'h36, 10'h2A5, 10'h1F0, 4'h3, 8'h00};
    tbl[1]  = '{8'h37, 10'h2A5, 10'h1F0, 4'h3, 8'hA5};
    tbl[2]  = '{8'h38, 10'h2A5, 10'h1F0, 4'h3, 8'hF0};
    tbl[3]  = '{8'h39, 10'h2A5, 10'h1F0, 4'h3, 8'h63};
    tbl[4]  = '{8'h39, 10'h3FF, 10'h2FF, 4'hF, 8'hBF};
    tbl[5]  = '{8'h37, 10'h15A, 10'h0C3, 4'h0, 8'h5A};
    tbl[6]  = '{8'h38, 10'h15A, 10'h0C3, 4'h0, 8'hC3};
    tbl[7]  = '{8'h39, 10'h15A, 10'h0C3, 4'h0, 8'h10};
    tbl[8]  = '{8'h3A, 10'h2A5, 10'h1F0, 4'h3, 8'hFF};
    tbl[9]  = '{8'h45, 10'h2A5, 10'h1F0, 4'h3, 8'hFF};
    tbl[10] = '{8'h46, 10'h2A5, 10'h1F0, 4'h3, 8'hFF};
    tbl[11] = '{8'hFF, 10'h2A5, 10'h1F0, 4'h3, 8'hFF};
    tbl[12] = '{8'h35, 10'h2A5, 10'h1F0, 4'h3, 8'h00};
    tbl[13] = '{8'h00, 10'h2A5, 10'h1F0, 4'h3, 8'h00};
    tbl[14] = '{8'h30, 10'h2A5, 10'h1F0, 4'h3, 8'h08};
    tbl[15] = '{8'h33, 10'h2A5, 10'h1F0, 4'h3, 8'h33};
    tbl[16] = '{8'h31, 10'h2A5, 10'h1F0, 4'h3, 8'h00};

    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    x_in = 10'h2A5; y_in = 10'h1F0; size_in = 4'h3;
    repeat (5) @(posedge clk);
    #1;
    check("reset oe", i2c_sda_oe, 1'b0);
    check("reset reg30", reg30, 8'h00);
    check("reset reg33", reg33, 8'h00);
    check("reset enabled", enabled, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset frame_read", frame_read, 1'b0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    write_regs("wr30=01", 8'h30, 8'h01);
    check("reg30 after 01", reg30, 8'h01);
    check("enabled after 01", enabled, 1'b0);

    write_regs("wr30=08", 8'h30, 8'h08);
    check("enabled after 08", enabled, 1'b1);
    write_regs("wr33=33", 8'h33, 8'h33);
    check("reg30 after cfg", reg30, 8'h08);
    check("reg33 after cfg", reg33, 8'h33);
    check("enabled after cfg", enabled, 1'b1);

    for (int i = 0; i < NV; i++) begin
      x_in = tbl[i].x; y_in = tbl[i].y; size_in = tbl[i].size;
      open_read($sformatf("tbl%0d", i), tbl[i].ptr);
      exp_q.push_back(tbl[i].exp);
      read_byte(d, 1'b0);
      sb_compare($sformatf("tbl%0d ptr=%02h x=%03h y=%03h s=%0h", i, tbl[i].ptr,
                           tbl[i].x, tbl[i].y, tbl[i].size), d);
      bus_stop();
    end

    // Burst write: pointer auto-increments through 0x31/0x32 (discarded) to 0x33.
    bus_start();
    write_byte(8'hB0, ack); check("burst addr ack", ack, 1'b1);
    write_byte(8'h30, ack); check("burst ptr ack", ack, 1'b1);
    write_byte(8'h09, ack); check("burst d0 ack", ack, 1'b1);
    write_byte(8'hAA, ack); check("burst d1 ack", ack, 1'b1);
    write_byte(8'h5C, ack); check("burst d2 ack", ack, 1'b1);
    write_byte(8'h44, ack); check("burst d3 ack", ack, 1'b1);
    bus_stop();
    check("burst reg30", reg30, 8'h09);
    check("burst enabled", enabled, 1'b0);
    check("burst reg33", reg33, 8'h44);

    // Full frame read from 0x36.
    x_in = 10'h2A5; y_in = 10'h1F0; size_in = 4'h3;
    fr0 = fr_cnt;
    open_read("frame", 8'h36);
    check("frame busy", busy, 1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h63);
    for (int k = 0; k < 12; k++) exp_q.push_back(8'hFF);
    for (int k = 0; k < 16; k++) begin
      read_byte(d, k < 15);
      sb_compare($sformatf("frame byte %0d", k), d);
    end
    bus_stop();
    check("frame busy after stop", busy, 1'b0);
    check("frame_read pulses", fr_cnt - fr0, 1);

    // Inputs change after the address ACK; data must come from the snapshot.
    open_read("snap", 8'h37);
    x_in = 10'h0C3; y_in = 10'h2FF; size_in = 4'hE;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hF0); exp_q.push_back(8'h63);
    for (int k = 0; k < 3; k++) begin
      read_byte(d, k < 2);
      sb_compare($sformatf("snap byte %0d", k), d);
    end
    bus_stop();

    // Foreign address: never ACKed, never busy.
    mon_on = 1'b1;
    bus_start();
    write_byte(8'h84, ack); check("foreign addr ack", ack, 1'b0);
    write_byte(8'h30, ack); check("foreign data ack", ack, 1'b0);
    bus_stop();
    #Q;
    mon_on = 1'b0;
    check("foreign oe cycles", mon_oe, 0);
    check("foreign busy cycles", mon_busy, 0);
    check("foreign reg30 kept", reg30, 8'h09);

    // Reset while driving a 0 bit of the second read byte.
    x_in = 10'h2A5; y_in = 10'h1F0; size_in = 4'h3;
    open_read("rst", 8'h36);
    exp_q.push_back(8'h00);
    read_byte(d, 1'b1);
    sb_compare("rst byte 0", d);
    read_bit(b);
    check("rst byte1 bit7", b, 1'b1);
    check("rst oe before reset", i2c_sda_oe, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst oe next cycle", i2c_sda_oe, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst reg30", reg30, 8'h00);
    reset = 1'b0;
    bus_stop();
    open_read("post-rst", 8'h36);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h63);
    for (int k = 0; k < 4; k++) begin
      read_byte(d, k < 3);
      sb_compare($sformatf("post-rst byte %0d", k), d);
    end
    bus_stop();

    check("scoreboard drained", exp_q.size(), 0);
    check("sda moved while scl high", oe_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
